// File: rtl/mux_pkg.sv
// Shared constants and helpers for the TDM channel multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_AUTO  = 1'b1;

  // Select width for an n-channel mux; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n1.sv
// Parametrised N:1 W-bit combinational mux built as a binary tree of 2:1 stages.
module mux_n1 import mux_pkg::*; #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = sel_width(N)
) (
  input  logic [N*W-1:0] d,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   y
);

  // Heap layout: node 0 is the root, leaves occupy N-1 .. 2N-2 in channel order.
  // Tree depth lv is steered by select bit SW-1-lv, so the root uses the MSB.
  logic [W-1:0] node [2*N-1];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      node[N-1+k] = d[k*W +: W];
    end
    for (int lv = SW-1; lv >= 0; lv--) begin
      for (int j = 0; j < (1 << lv); j++) begin
        node[(1 << lv) - 1 + j] = sel[SW-1-lv] ? node[2*((1 << lv) - 1 + j) + 2]
                                                : node[2*((1 << lv) - 1 + j) + 1];
      end
    end
  end

  assign y = node[0];

endmodule

// File: rtl/mux_tdm_seq.sv
// TDM sampler: picks one channel (fixed or round-robin) into a registered
// output slot with a valid/ready style handshake.
module mux_tdm_seq import mux_pkg::*; #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] d,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           en,
  input  logic           out_ready,
  output logic [W-1:0]   y,
  output logic [SW-1:0]  ch,
  output logic           y_valid
);

  logic [SW-1:0] cnt;
  logic [SW-1:0] active;
  logic [W-1:0]  mux_y;
  logic          load;
  logic          stall;

  assign load   = en && (!y_valid || out_ready);
  assign stall  = y_valid && !out_ready;
  assign active = (mode == MODE_AUTO) ? cnt : sel;

  mux_n1 #(.N(N), .W(W)) u_mux (
    .d   (d),
    .sel (active),
    .y   (mux_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      ch      <= '0;
      y_valid <= 1'b0;
      cnt     <= '0;
    end else begin
      if (load) begin
        y       <= mux_y;
        ch      <= active;
        y_valid <= 1'b1;
      end else if (out_ready) begin
        y_valid <= 1'b0;
      end
      // A held sample freezes the scan position even if mode drops to fixed.
      if (mode == MODE_FIXED) begin
        if (!stall) cnt <= '0;
      end else if (load) begin
        cnt <= cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_tdm_seq.sv
// Directed + random scoreboard bench for mux_tdm_seq (N=4, W=8).
module tb_mux_tdm_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d = 32'h44332211;
  logic [1:0]  sel = 2'd0;
  logic        mode = 1'b0;
  logic        en = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  y;
  logic [1:0]  ch;
  logic        y_valid;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_y = 8'h00;
  logic [1:0] m_ch = 2'd0;
  logic       m_v = 1'b0;
  logic [1:0] m_cnt = 2'd0;
  logic [9:0] sb [$];

  mux_tdm_seq #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .sel       (sel),
    .mode      (mode),
    .en        (en),
    .out_ready (out_ready),
    .y         (y),
    .ch        (ch),
    .y_valid   (y_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic consume();
    logic [9:0] e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("sb_y", {24'd0, y}, {24'd0, e[9:2]});
      chk("sb_ch", {30'd0, ch}, {30'd0, e[1:0]});
    end
  endtask

  task automatic step(input logic r, input logic e, input logic m,
                      input logic [1:0] s, input logic o);
    logic       ld;
    logic       st;
    logic [1:0] act;
    @(negedge clk);
    rst = r; en = e; mode = m; sel = s; out_ready = o;
    #1;
    if (r) begin
      m_y = 8'h00; m_ch = 2'd0; m_v = 1'b0; m_cnt = 2'd0;
      sb.delete();
    end else begin
      if (y_valid && o) consume();
      ld  = e && (!m_v || o);
      st  = m_v && !o;
      act = m ? m_cnt : s;
      if (ld) begin
        m_y  = d[act*8 +: 8];
        m_ch = act;
        m_v  = 1'b1;
        sb.push_back({m_y, m_ch});
      end else if (o) begin
        m_v = 1'b0;
      end
      if (!m) begin
        if (!st) m_cnt = 2'd0;
      end else if (ld) begin
        m_cnt = m_cnt + 2'd1;
      end
    end
    @(posedge clk);
    #1;
    chk("y_valid", {31'd0, y_valid}, {31'd0, m_v});
    chk("y", {24'd0, y}, {24'd0, m_y});
    chk("ch", {30'd0, ch}, {30'd0, m_ch});
  endtask

  initial begin
    logic [7:0] seq_y [6];
    logic [1:0] seq_ch [6];
    seq_y  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
    seq_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // reset state
    step(1, 1, 0, 2'd3, 1);
    step(1, 0, 0, 2'd0, 0);
    chk("rst_y", {24'd0, y}, 32'h0);
    chk("rst_valid", {31'd0, y_valid}, 32'h0);

    // fixed select
    step(0, 1, 0, 2'd2, 1);
    chk("fixed_y", {24'd0, y}, 32'h33);
    chk("fixed_ch", {30'd0, ch}, 32'd2);

    // round-robin with wrap
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 2'd0, 1);
      chk("scan_y", {24'd0, y}, {24'd0, seq_y[i]});
      chk("scan_ch", {30'd0, ch}, {30'd0, seq_ch[i]});
    end

    // stall: everything frozen while d/en/sel/mode toggle
    for (int i = 0; i < 3; i++) begin
      d = $urandom();
      step(0, i[0], i[1], 2'(i), 0);
      chk("stall_y", {24'd0, y}, 32'h22);
      chk("stall_ch", {30'd0, ch}, 32'd1);
    end
    d = 32'h44332211;
    step(0, 1, 1, 2'd0, 1);
    chk("resume_ch", {30'd0, ch}, 32'd2);
    chk("resume_y", {24'd0, y}, 32'h33);

    // drain: valid drops, data retained
    step(0, 0, 1, 2'd0, 1);
    chk("drain_valid", {31'd0, y_valid}, 32'h0);
    chk("drain_y", {24'd0, y}, 32'h33);

    // out_ready with nothing held is harmless
    step(0, 0, 1, 2'd0, 1);

    // scan to ch=2 then reset with a concurrent load
    for (int i = 0; i < 4; i++) step(0, 1, 1, 2'd0, 1);
    chk("pre_rst_ch", {30'd0, ch}, 32'd2);
    step(1, 1, 1, 2'd0, 1);
    chk("mid_rst_y", {24'd0, y}, 32'h0);
    chk("mid_rst_ch", {30'd0, ch}, 32'd0);
    chk("mid_rst_valid", {31'd0, y_valid}, 32'h0);
    step(0, 1, 1, 2'd0, 1);
    chk("post_rst_ch", {30'd0, ch}, 32'd0);
    chk("post_rst_y", {24'd0, y}, 32'h11);

    // mode 1->0->1 with cnt=3 restarts at channel 0
    step(0, 1, 1, 2'd0, 1);
    step(0, 1, 1, 2'd0, 1);
    step(0, 0, 0, 2'd1, 1);
    step(0, 1, 1, 2'd0, 1);
    chk("mode_return_ch", {30'd0, ch}, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 40; i++) begin
      d = $urandom();
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 2'd0, 1);
    step(0, 0, 0, 2'd0, 1);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_tdm_seq.md
MUX_TDM_SEQ -- requirements
Module: mux_tdm_seq

Interface
REQ-001 SHALL have parameter N, default 4, meaning channel count (power of 2, 2..16).
REQ-002 SHALL have parameter W, default 8, meaning data width per channel in bits.
REQ-003 SHALL have localparam SW = clog2(N), meaning select/channel-index width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 d  input  N*W  packed channel data; channel k occupies d[k*W +: W].
REQ-007 sel  input  SW  channel select, used in fixed mode.
REQ-008 mode  input  1  0 = fixed select, 1 = auto round-robin scan.
REQ-009 en  input  1  request to capture a new sample.
REQ-010 out_ready  input  1  downstream accepts y this cycle.
REQ-011 y  output  W  registered selected data.
REQ-012 ch  output  SW  channel index the current y was taken from.
REQ-013 y_valid  output  1  y/ch hold an unconsumed sample.

Function
REQ-014 Load condition: load = en && (!y_valid || out_ready); evaluated every cycle.
REQ-015 On load, y SHALL capture d slice of the active channel and ch SHALL capture that channel index; latency 1 cycle from en to y_valid.
REQ-016 Active channel: sel when mode=0; scan counter cnt when mode=1.
REQ-017 cnt SHALL increment by 1 on each load while mode=1, wrapping N-1 -> 0.
REQ-018 cnt SHALL hold when no load occurs; cnt SHALL clear to 0 on any cycle with mode=0.
REQ-019 y_valid SHALL set on load; clear when out_ready && !load; hold otherwise.
REQ-020 Stall: while y_valid && !out_ready, y, ch, y_valid and cnt SHALL stay unchanged regardless of d, sel, mode, en.
REQ-021 Simultaneous consume and load (y_valid, out_ready, en all 1): new sample replaces old, y_valid stays 1, no bubble.
REQ-022 sel changes take effect on the next load only; no combinational path from sel, d or mode to y.
REQ-023 out_ready with y_valid=0 SHALL have no effect.
REQ-024 mode switch 0->1: first auto sample SHALL come from channel 0.

Reset
REQ-025 rst=1 at a rising edge SHALL force y=0, ch=0, y_valid=0, cnt=0, overriding all other inputs including a concurrent load.
REQ-026 Reset mid-stream SHALL discard any held sample; first load after release restarts scan at channel 0.

Structure
REQ-027 Shared package mux_pkg SHALL hold the mode encoding constants (MODE_FIXED=0, MODE_AUTO=1) and a clog2-based width helper.
REQ-028 Selection SHALL be a sub-module mux_n1 (parametrised N:1, W-bit, combinational binary tree of 2:1 ternary stages); mux_tdm_seq adds counter, registers and handshake.

Verification
REQ-029 N=4,W=8, d={8'h44,8'h33,8'h22,8'h11}, mode=0, sel=2, en=1, out_ready=1 -> one cycle later y=8'h33, ch=2, y_valid=1.
REQ-030 Same d, mode=1, en=1, out_ready=1 for 6 cycles -> y sequence 11,22,33,44,11,22; ch 0,1,2,3,0,1 (wrap).
REQ-031 mode=1, y_valid=1, out_ready=0 for 3 cycles while d and en toggle -> y, ch, cnt frozen; after out_ready=1 scan resumes at next channel.
REQ-032 en=0, out_ready=1 with y_valid=1 -> y_valid drops next cycle; y retains last value.
REQ-033 rst=1 asserted during auto scan at ch=2 with en=1 -> next cycle y=0, ch=0, y_valid=0; after release first sample from channel 0.
REQ-034 mode 1->0->1 mid-scan (cnt=3) -> first auto sample after return is channel 0.
